cpu_datapath: RTL and testbench

- 32-bit single-bus CPU datapath.
- Contains 16 general registers R0–R15, PC, IR, Y, 64-bit Z, HI, LO, MAR and MDR around one shared 32-bit bus, plus a combinational ALU.
- An external control unit (or bench) drives one-hot register-out and register-in strobes each cycle.
- Sits between the control unit and memory: MAR drives the address, and MDR captures memory data.

---
 rtl/cpu_datapath_if.sv | 33 +++
 rtl/cpu_datapath.sv | 126 ++++++++++++
 tb/tb_cpu_datapath.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Control/memory bundle for cpu_datapath.
// master: control unit (or bench) driving strobes, ALU select and memory read data;
//         it observes the bus, the memory address and the instruction register.
// slave:  the datapath itself.
// Rin/Rout bit n is the load/drive strobe for general register Rn.
interface cpu_datapath_if #(
  parameter int unsigned WIDTH = 32
);
  logic [15:0]      Rin;
  logic [15:0]      Rout;
  logic             PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout;
  logic             HIin, HIout, LOin, LOout, MARin, MDRin, MDRout;
  logic             Read, IncPC;
  logic [3:0]       ALUselect;
  logic [WIDTH-1:0] Mdatain;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] mar_out;
  logic [WIDTH-1:0] ir_out;

  modport master (
    output Rin, Rout, PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout,
    output HIin, HIout, LOin, LOout, MARin, MDRin, MDRout, Read, IncPC,
    output ALUselect, Mdatain,
    input  bus_out, mar_out, ir_out
  );

  modport slave (
    input  Rin, Rout, PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout,
    input  HIin, HIout, LOin, LOout, MARin, MDRin, MDRout, Read, IncPC,
    input  ALUselect, Mdatain,
    output bus_out, mar_out, ir_out
  );
endinterface

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: R0-R15, PC, IR, Y, 64-bit Z, HI, LO, MAR, MDR around one
// shared bus, plus a combinational ALU (A = Y, B = bus, 64-bit result into Z).
// Ports:
//   clock  - sole clock, rising edge
//   clear  - synchronous active-low reset, overrides all loads
//   bus_if - slave side of cpu_datapath_if (strobes, ALU select, memory data in;
//            bus_out, mar_out, ir_out out)
module cpu_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clock,
  input  logic          clear,
  cpu_datapath_if.slave bus_if
);
  localparam int unsigned ShW = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_q [16];
  logic [WIDTH-1:0]   r_d [16];
  logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, y_q, y_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_res;

  // Bus mux: later assignments win, so the highest-priority source is written last.
  always_comb begin
    bus = '0;
    if (bus_if.MDRout)   bus = mdr_q;
    if (bus_if.PCout)    bus = pc_q;
    if (bus_if.Zlowout)  bus = z_q[WIDTH-1:0];
    if (bus_if.Zhighout) bus = z_q[2*WIDTH-1:WIDTH];
    if (bus_if.LOout)    bus = lo_q;
    if (bus_if.HIout)    bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (bus_if.Rout[i]) bus = r_q[i];
    end
  end

  // ALU
  logic [WIDTH-1:0]          a, b;
  logic [ShW-1:0]            sh;
  logic [2*WIDTH-1:0]        ror_w, rol_w;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quo, rem;

  always_comb begin
    a     = y_q;
    b     = bus;
    sh    = b[ShW-1:0];
    // Rotates via a doubled operand: low half of the right shift, high half of the left.
    ror_w = {a, a} >> sh;
    rol_w = {a, a} << sh;
    prod  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    quo   = '0;
    rem   = '0;
    if (b != '0) begin
      quo = $signed(a) / $signed(b);
      rem = $signed(a) % $signed(b);
    end
    alu_res = '0;
    if (bus_if.IncPC) begin
      alu_res = {{WIDTH{1'b0}}, b + 1'b1};
    end else begin
      unique case (bus_if.ALUselect)
        4'b0000: alu_res = {{WIDTH{1'b0}}, a + b};
        4'b0001: alu_res = {{WIDTH{1'b0}}, a - b};
        4'b0010: alu_res = {{WIDTH{1'b0}}, a >> sh};
        4'b0011: alu_res = {{WIDTH{1'b0}}, a << sh};
        4'b0100: alu_res = {{WIDTH{1'b0}}, ror_w[WIDTH-1:0]};
        4'b0101: alu_res = {{WIDTH{1'b0}}, rol_w[2*WIDTH-1:WIDTH]};
        4'b0110: alu_res = {{WIDTH{1'b0}}, a & b};
        4'b0111: alu_res = {{WIDTH{1'b0}}, a | b};
        4'b1000: alu_res = prod;
        4'b1001: alu_res = {rem, quo};
        4'b1010: alu_res = {{WIDTH{1'b0}}, {WIDTH{1'b0}} - b};
        4'b1011: alu_res = {{WIDTH{1'b0}}, ~b};
        default: alu_res = {{WIDTH{1'b0}}, b};
      endcase
    end
  end

  // Next-state
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_d[i] = bus_if.Rin[i] ? bus : r_q[i];
    end
    pc_d  = bus_if.PCin  ? bus : pc_q;
    ir_d  = bus_if.IRin  ? bus : ir_q;
    y_d   = bus_if.Yin   ? bus : y_q;
    hi_d  = bus_if.HIin  ? bus : hi_q;
    lo_d  = bus_if.LOin  ? bus : lo_q;
    mar_d = bus_if.MARin ? bus : mar_q;
    mdr_d = mdr_q;
    if (bus_if.MDRin) mdr_d = bus_if.Read ? bus_if.Mdatain : bus;
    z_d   = bus_if.Zin ? alu_res : z_q;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      y_q   <= y_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      z_q   <= z_d;
    end
  end

  assign bus_if.bus_out = bus;
  assign bus_if.mar_out = mar_q;
  assign bus_if.ir_out  = ir_q;
endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;
  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  cpu_datapath_if ifc ();
  cpu_datapath dut (.clock(clock), .clear(clear), .bus_if(ifc.slave));

  localparam logic [15:0] PCI  = 16'h0001, PCO  = 16'h0002, IRI  = 16'h0004, YI   = 16'h0008;
  localparam logic [15:0] ZI   = 16'h0010, ZHO  = 16'h0020, ZLO  = 16'h0040, HII  = 16'h0080;
  localparam logic [15:0] HIO  = 16'h0100, LOI  = 16'h0200, LOO  = 16'h0400, MARI = 16'h0800;
  localparam logic [15:0] MDRI = 16'h1000, MDRO = 16'h2000, RD   = 16'h4000, INC  = 16'h8000;

  typedef struct {
    logic [15:0] rout;
    logic [15:0] rin;
    logic [15:0] ctl;
    logic [3:0]  alu;
    logic [31:0] md;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ifc.Rout = v.rout;  ifc.Rin = v.rin;
    ifc.PCin = v.ctl[0];  ifc.PCout = v.ctl[1];  ifc.IRin = v.ctl[2];  ifc.Yin = v.ctl[3];
    ifc.Zin = v.ctl[4];  ifc.Zhighout = v.ctl[5];  ifc.Zlowout = v.ctl[6];  ifc.HIin = v.ctl[7];
    ifc.HIout = v.ctl[8];  ifc.LOin = v.ctl[9];  ifc.LOout = v.ctl[10];  ifc.MARin = v.ctl[11];
    ifc.MDRin = v.ctl[12];  ifc.MDRout = v.ctl[13];  ifc.Read = v.ctl[14];  ifc.IncPC = v.ctl[15];
    ifc.ALUselect = v.alu;  ifc.Mdatain = v.md;
  endtask

  function automatic vec_t mk(input logic [15:0] rout, input logic [15:0] rin,
                              input logic [15:0] ctl, input logic [3:0] alu,
                              input logic [31:0] md, input logic chk, input logic [31:0] exp);
    vec_t v;
    v.rout = rout; v.rin = rin; v.ctl = ctl; v.alu = alu; v.md = md; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  // Drive, optionally compare bus before the edge, clock once, settle.
  task automatic run(input vec_t v, input string name);
    drive(v);
    #1;
    if (v.chk) check(name, ifc.bus_out, v.exp);
    @(posedge clock);
    #1;
  endtask

  task automatic ld(input logic [31:0] md);
    vecs.push_back(mk(16'h0, 16'h0, MDRI | RD, 4'h0, md, 1'b0, 32'h0));
  endtask

  task automatic ex(input logic [15:0] rout, input logic [15:0] rin, input logic [15:0] ctl,
                    input logic [3:0] alu, input logic [31:0] exp);
    vecs.push_back(mk(rout, rin, ctl, alu, 32'h0, 1'b1, exp));
  endtask

  vec_t idle;

  initial begin
    idle = mk(16'h0, 16'h0, 16'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    drive(idle);
    @(posedge clock);
    #1;

    // Reset: load nonzero values everywhere, then clear (with loads asserted).
    run(mk(16'h0, 16'h0, MDRI | RD, 4'h0, 32'hDEADBEEF, 1'b0, 32'h0), "pre");
    run(mk(16'h0, 16'hFFFF, MDRO | PCI | IRI | YI | HII | LOI | MARI, 4'h0, 32'h0, 1'b1,
           32'hDEADBEEF), "pre_bus");
    run(mk(16'h0, 16'h0, MDRO | ZI, 4'h0, 32'h0, 1'b0, 32'h0), "pre_z");
    check("pre_mar", ifc.mar_out, 32'hDEADBEEF);
    check("pre_ir", ifc.ir_out, 32'hDEADBEEF);
    clear = 1'b0;
    run(mk(16'h0, 16'hFFFF, MDRI | RD | PCI | YI | ZI | MARI | IRI, 4'h0, 32'h55, 1'b0, 32'h0),
        "clr");
    clear = 1'b1;
    drive(idle);
    #1;
    check("rst_idle_bus", ifc.bus_out, 32'h0);
    check("rst_mar", ifc.mar_out, 32'h0);
    check("rst_ir", ifc.ir_out, 32'h0);
    for (int i = 0; i < 16; i++) begin
      ifc.Rout = 16'(1 << i);
      #1;
      check($sformatf("rst_r%0d", i), ifc.bus_out, 32'h0);
    end
    ifc.Rout = 16'h0;
    run(mk(16'h0, 16'h0, HIO, 4'h0, 32'h0, 1'b1, 32'h0), "rst_hi");
    run(mk(16'h0, 16'h0, LOO, 4'h0, 32'h0, 1'b1, 32'h0), "rst_lo");
    run(mk(16'h0, 16'h0, ZHO, 4'h0, 32'h0, 1'b1, 32'h0), "rst_zh");
    run(mk(16'h0, 16'h0, ZLO, 4'h0, 32'h0, 1'b1, 32'h0), "rst_zl");
    run(mk(16'h0, 16'h0, MDRO, 4'h0, 32'h0, 1'b1, 32'h0), "rst_mdr");
    // Y observed through Z = Y + 0.
    run(mk(16'h0, 16'h0, ZI, 4'h0, 32'h0, 1'b0, 32'h0), "rst_y_z");
    run(mk(16'h0, 16'h0, ZLO, 4'h0, 32'h0, 1'b1, 32'h0), "rst_y");

    // MDR load path
    ld(32'h12); ex(16'h0, 16'h0004, MDRO, 4'h0, 32'h12);
    ld(32'h14); ex(16'h0, 16'h0008, MDRO, 4'h0, 32'h14);
    ld(32'h18); ex(16'h0, 16'h0002, MDRO, 4'h0, 32'h18);
    ex(16'h0004, 16'h0, 16'h0, 4'h0, 32'h12);
    // Fetch
    ex(16'h0, 16'h0, PCO | MARI | INC | ZI, 4'h0, 32'h0);
    vecs.push_back(mk(16'h0, 16'h0, ZLO | PCI | RD | MDRI, 4'h0, 32'h28918000, 1'b1, 32'h1));
    ex(16'h0, 16'h0, MDRO | IRI, 4'h0, 32'h28918000);
    ex(16'h0, 16'h0, PCO, 4'h0, 32'h1);
    // AND R1,R2,R3
    ex(16'h0004, 16'h0, YI, 4'h0, 32'h12);
    ex(16'h0008, 16'h0, ZI, 4'h6, 32'h14);
    ex(16'h0, 16'h0002, ZLO, 4'h0, 32'h10);
    ex(16'h0002, 16'h0, 16'h0, 4'h0, 32'h10);
    // MUL
    ld(32'hFFFFFFFF); ex(16'h0, 16'h0, MDRO | YI, 4'h0, 32'hFFFFFFFF);
    ld(32'h2);        ex(16'h0, 16'h0, MDRO | ZI, 4'h8, 32'h2);
    ex(16'h0, 16'h0, ZHO | HII, 4'h0, 32'hFFFFFFFF);
    ex(16'h0, 16'h0, ZLO | LOI, 4'h0, 32'hFFFFFFFE);
    ex(16'h0, 16'h0, HIO, 4'h0, 32'hFFFFFFFF);
    ex(16'h0, 16'h0, LOO, 4'h0, 32'hFFFFFFFE);
    // DIV 7 / -2 = -3 rem 1
    ld(32'h7);        ex(16'h0, 16'h0, MDRO | YI, 4'h0, 32'h7);
    ld(32'hFFFFFFFE); ex(16'h0, 16'h0, MDRO | ZI, 4'h9, 32'hFFFFFFFE);
    ex(16'h0, 16'h0, ZHO | HII, 4'h0, 32'h1);
    ex(16'h0, 16'h0, ZLO | LOI, 4'h0, 32'hFFFFFFFD);
    ex(16'h0, 16'h0, HIO, 4'h0, 32'h1);
    ex(16'h0, 16'h0, LOO, 4'h0, 32'hFFFFFFFD);
    // DIV by zero
    ld(32'h0); ex(16'h0, 16'h0, MDRO | ZI, 4'h9, 32'h0);
    ex(16'h0, 16'h0, ZHO, 4'h0, 32'h0);
    ex(16'h0, 16'h0, ZLO, 4'h0, 32'h0);
    // Shifts/rotates and remaining ops with Y=0x80000001, B=1
    ld(32'h80000001); ex(16'h0, 16'h0, MDRO | YI, 4'h0, 32'h80000001);
    ld(32'h1);
    ex(16'h0, 16'h0, MDRO | ZI, 4'h5, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'h00000003);
    ex(16'h0, 16'h0, ZHO, 4'h0, 32'h0);
    ex(16'h0, 16'h0, MDRO | ZI, 4'h2, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'h40000000);
    ex(16'h0, 16'h0, MDRO | ZI, 4'h4, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'hC0000000);
    ex(16'h0, 16'h0, MDRO | ZI, 4'h3, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'h00000002);
    ex(16'h0, 16'h0, MDRO | ZI, 4'h1, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'h80000000);
    ex(16'h0, 16'h0, MDRO | ZI, 4'h0, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'h80000002);
    ex(16'h0, 16'h0, MDRO | ZI, 4'h7, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'h80000001);
    ex(16'h0, 16'h0, MDRO | ZI, 4'hA, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'hFFFFFFFF);
    ex(16'h0, 16'h0, ZHO, 4'h0, 32'h0);
    ex(16'h0, 16'h0, MDRO | ZI, 4'hB, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'hFFFFFFFE);
    ex(16'h0, 16'h0, MDRO | ZI, 4'hC, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'h00000001);
    ex(16'h0, 16'h0, MDRO | ZI | INC, 4'h8, 32'h1); ex(16'h0, 16'h0, ZLO, 4'h0, 32'h00000002);
    // Bus priority
    ld(32'hAAAA); ex(16'h0, 16'h0001, MDRO, 4'h0, 32'hAAAA);
    ld(32'h5555); ex(16'h0, 16'h0020, MDRO, 4'h0, 32'h5555);
    ex(16'h0021, 16'h0, 16'h0, 4'h0, 32'hAAAA);
    ex(16'h000A, 16'h0, 16'h0, 4'h0, 32'h10);
    ex(16'h0020, 16'h0, HIO | MDRO, 4'h0, 32'h5555);
    ex(16'h0, 16'h0, HIO | LOO, 4'h0, 32'h1);
    ex(16'h0, 16'h0, LOO | ZHO, 4'h0, 32'hFFFFFFFD);
    ex(16'h0, 16'h0, ZHO | ZLO, 4'h0, 32'h0);
    ex(16'h0, 16'h0, ZLO | PCO, 4'h0, 32'h2);
    ex(16'h0, 16'h0, PCO | MDRO, 4'h0, 32'h1);

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("vec%0d", i));

    // Registers that are only visible on dedicated outputs
    check("ir_after_fetch", ifc.ir_out, 32'h28918000);
    run(mk(16'h0, 16'h0, MDRI | RD, 4'h0, 32'h100, 1'b0, 32'h0), "mar_ld");
    run(mk(16'h0, 16'h0, MDRO | MARI, 4'h0, 32'h0, 1'b1, 32'h100), "mar_bus");
    check("mar_load", ifc.mar_out, 32'h100);
    // Read=0: MDR loads from the bus instead of Mdatain
    run(mk(16'h0002, 16'h0, MDRI, 4'h0, 32'h777, 1'b1, 32'h10), "mdr_bus");
    run(mk(16'h0, 16'h0, MDRO, 4'h0, 32'h0, 1'b1, 32'h10), "mdr_from_bus");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
